// File: rtl/counter_ctrl_if.sv
// Requester-side handshake bundle for counter_ctrl: two command ports
// plus the grant/completion status returned to them.
interface counter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             REQ_A;
  logic [1:0]       CMD_A;
  logic [WIDTH-1:0] DATA_A;
  logic             REQ_B;
  logic [1:0]       CMD_B;
  logic [WIDTH-1:0] DATA_B;
  logic             GNT_A;
  logic             GNT_B;
  logic             DONE_A;
  logic             DONE_B;
  logic             RCO_HIT;
  logic             BUSY;

  modport master (
    output REQ_A, CMD_A, DATA_A, REQ_B, CMD_B, DATA_B,
    input  GNT_A, GNT_B, DONE_A, DONE_B, RCO_HIT, BUSY
  );

  modport slave (
    input  REQ_A, CMD_A, DATA_A, REQ_B, CMD_B, DATA_B,
    output GNT_A, GNT_B, DONE_A, DONE_B, RCO_HIT, BUSY
  );
endinterface

// File: rtl/counter_ctrl.sv
// Round-robin two-requester sequencer driving a 4-mode counter for an exact
// number of enabled cycles, with optional early stop on counter ripple-carry.
module counter_ctrl #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_RCO = 1'b1
) (
  input  logic             clk,
  input  logic             RESET,
  counter_ctrl_if.slave    bus,
  output logic             CNT_ENABLE,
  output logic [1:0]       CNT_MODO,
  output logic [WIDTH-1:0] CNT_D,
  input  logic             CNT_RCO
);

  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

  localparam logic [1:0] CHARGE = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             last_b;
  logic             own_b;

  logic             pick_b;
  logic [1:0]       sel_cmd;
  logic [WIDTH-1:0] sel_data;
  logic [CNT_W-1:0] sel_len;
  logic             rco_stop;

  // Winner selection: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    pick_b = bus.REQ_B;
    if (bus.REQ_A && bus.REQ_B) pick_b = !last_b;
    sel_cmd  = pick_b ? bus.CMD_B  : bus.CMD_A;
    sel_data = pick_b ? bus.DATA_B : bus.DATA_A;
    sel_len  = sel_data[CNT_W-1:0];
  end

  // CNT_MODO holds the latched command while executing, so it doubles as the mode register.
  assign rco_stop = STOP_ON_RCO && (CNT_MODO != CHARGE) && CNT_RCO;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      rem         <= '0;
      last_b      <= 1'b1;
      own_b       <= 1'b0;
      bus.GNT_A   <= 1'b0;
      bus.GNT_B   <= 1'b0;
      bus.DONE_A  <= 1'b0;
      bus.DONE_B  <= 1'b0;
      bus.RCO_HIT <= 1'b0;
      bus.BUSY    <= 1'b0;
      CNT_ENABLE  <= 1'b0;
      CNT_MODO    <= CHARGE;
      CNT_D       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.REQ_A || bus.REQ_B) begin
            own_b     <= pick_b;
            bus.GNT_A <= !pick_b;
            bus.GNT_B <= pick_b;
            bus.BUSY  <= 1'b1;
            CNT_D     <= sel_data;
            if (sel_cmd == CHARGE) begin
              rem        <= CNT_W'(1);
              CNT_ENABLE <= 1'b1;
              CNT_MODO   <= CHARGE;
              state      <= EXEC;
            end else if (sel_len != '0) begin
              rem        <= sel_len;
              CNT_ENABLE <= 1'b1;
              CNT_MODO   <= sel_cmd;
              state      <= EXEC;
            end else begin
              bus.DONE_A <= !pick_b;
              bus.DONE_B <= pick_b;
              state      <= FIN;
            end
          end
        end
        EXEC: begin
          if (rco_stop || rem == CNT_W'(1)) begin
            CNT_ENABLE  <= 1'b0;
            CNT_MODO    <= CHARGE;
            bus.DONE_A  <= !own_b;
            bus.DONE_B  <= own_b;
            bus.RCO_HIT <= rco_stop;
            state       <= FIN;
          end else begin
            rem <= rem - CNT_W'(1);
          end
        end
        FIN: begin
          bus.GNT_A   <= 1'b0;
          bus.GNT_B   <= 1'b0;
          bus.DONE_A  <= 1'b0;
          bus.DONE_B  <= 1'b0;
          bus.RCO_HIT <= 1'b0;
          bus.BUSY    <= 1'b0;
          last_b      <= own_b;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed vector table, hand-written multi-cycle
// sequences, then random traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_counter_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             RESET;
  logic             CNT_ENABLE;
  logic [1:0]       CNT_MODO;
  logic [WIDTH-1:0] CNT_D;
  logic             CNT_RCO;

  counter_ctrl_if #(.WIDTH(WIDTH)) bus();

  counter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STOP_ON_RCO(1'b1)) dut (
    .clk(clk), .RESET(RESET), .bus(bus.slave),
    .CNT_ENABLE(CNT_ENABLE), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D), .CNT_RCO(CNT_RCO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_who = 1;

  typedef struct {
    int          who;
    logic [1:0]  cmd;
    logic [31:0] data;
    int          rco_at;
    int          exp_en;
    bit          exp_rco;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int who, input logic req, input logic [1:0] cmd, input logic [31:0] data);
    if (who == 0) begin
      bus.REQ_A = req; bus.CMD_A = cmd; bus.DATA_A = data;
    end else begin
      bus.REQ_B = req; bus.CMD_B = cmd; bus.DATA_B = data;
    end
  endtask

  task automatic set_req(input int who, input logic req);
    if (who == 0) bus.REQ_A = req;
    else          bus.REQ_B = req;
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? bus.GNT_A : bus.GNT_B;
  endfunction

  function automatic logic done_of(input int who);
    return (who == 0) ? bus.DONE_A : bus.DONE_B;
  endfunction

  task automatic chk_reset_vals(input string nm);
    chk({nm, " gnt"},  {bus.GNT_A, bus.GNT_B}, 2'b00);
    chk({nm, " done"}, {bus.DONE_A, bus.DONE_B}, 2'b00);
    chk({nm, " rco_hit/busy/en"}, {bus.RCO_HIT, bus.BUSY, CNT_ENABLE}, 3'b000);
    chk({nm, " modo"}, CNT_MODO, 2'b11);
    chk({nm, " d"}, CNT_D, 32'h0);
  endtask

  // Requests are already driven at the current negedge with the DUT in IDLE.
  task automatic serve_one(input int who, input logic [1:0] cmd, input logic [31:0] data,
                           input int rco_at, input int exp_en, input bit exp_rco,
                           input bit drop_early, input string nm);
    int w;
    int en;
    bit got;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w++;
      if (bus.GNT_A || bus.GNT_B) break;
    end
    chk({nm, " grant latency"}, w, 1);
    chk({nm, " owner"}, {bus.GNT_B, bus.GNT_A}, (who == 0) ? 2'b01 : 2'b10);
    chk({nm, " busy"}, bus.BUSY, 1'b1);
    drive(who, drop_early ? 1'b0 : 1'b1, ~cmd, ~data);
    en  = 0;
    got = 0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      if (done_of(who)) begin
        got = 1;
        break;
      end
      if (CNT_ENABLE) begin
        en++;
        chk({nm, " run mode"}, CNT_MODO, cmd);
        chk({nm, " run d"}, CNT_D, data);
        CNT_RCO = (rco_at != 0 && en == rco_at);
      end else begin
        CNT_RCO = 1'b0;
      end
    end
    CNT_RCO = 1'b0;
    chk({nm, " done seen"}, got, 1'b1);
    chk({nm, " enabled cycles"}, en, exp_en);
    chk({nm, " rco_hit"}, bus.RCO_HIT, exp_rco);
    chk({nm, " gnt at done"}, gnt_of(who), 1'b1);
    chk({nm, " other done"}, done_of(1 - who), 1'b0);
    chk({nm, " fin en/modo"}, {CNT_ENABLE, CNT_MODO}, 3'b011);
    set_req(who, 1'b0);
    @(negedge clk);
    chk({nm, " idle after"}, {done_of(who), gnt_of(who), bus.BUSY, bus.RCO_HIT}, 4'b0000);
    last_who = who;
  endtask

  initial begin
    bit          pend[2];
    logic [1:0]  pc[2];
    logic [31:0] pd[2];
    int          pr[2];
    int          win;
    int          n;
    int          ee;
    bit          er;

    tbl[0] = '{0, 2'b11, 32'hDEADBEEF, 0, 1, 1'b0};
    tbl[1] = '{0, 2'b00, 32'd5,        0, 5, 1'b0};
    tbl[2] = '{1, 2'b10, 32'd0,        0, 0, 1'b0};
    tbl[3] = '{0, 2'b00, 32'd100,      4, 4, 1'b1};
    tbl[4] = '{1, 2'b11, 32'h12345678, 1, 1, 1'b0};
    tbl[5] = '{1, 2'b01, 32'hABCD0003, 0, 3, 1'b0};
    tbl[6] = '{0, 2'b10, 32'd2,        2, 2, 1'b1};
    tbl[7] = '{1, 2'b01, 32'd1,        0, 1, 1'b0};

    RESET   = 1'b0;
    CNT_RCO = 1'b0;
    drive(0, 1'b0, 2'b00, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    RESET = 1'b1;
    @(negedge clk);
    chk_reset_vals("post-release idle");

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].who, 1'b1, tbl[i].cmd, tbl[i].data);
      serve_one(tbl[i].who, tbl[i].cmd, tbl[i].data, tbl[i].rco_at,
                tbl[i].exp_en, tbl[i].exp_rco, 1'b0, $sformatf("vec%0d", i));
    end

    // Simultaneous requests, then A re-requests while B is still waiting.
    drive(0, 1'b1, 2'b01, 32'd3);
    drive(1, 1'b1, 2'b01, 32'd3);
    serve_one(0, 2'b01, 32'd3, 0, 3, 1'b0, 1'b0, "rr A first");
    drive(0, 1'b1, 2'b01, 32'd3);
    serve_one(1, 2'b01, 32'd3, 0, 3, 1'b0, 1'b0, "rr B second");
    serve_one(0, 2'b01, 32'd3, 0, 3, 1'b0, 1'b0, "rr A third");

    // Asynchronous reset in the 3rd enabled cycle of a 10-cycle run.
    drive(0, 1'b1, 2'b00, 32'd10);
    @(negedge clk);
    chk("midrst grant", bus.GNT_A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst running", CNT_ENABLE, 1'b1);
    #2 RESET = 1'b0;
    #1 chk_reset_vals("midrst async");
    drive(0, 1'b0, 2'b00, 32'd0);
    @(negedge clk);
    chk_reset_vals("midrst held");
    RESET    = 1'b1;
    last_who = 1;
    drive(1, 1'b1, 2'b00, 32'd2);
    serve_one(1, 2'b00, 32'd2, 0, 2, 1'b0, 1'b0, "post-reset B");

    // Random traffic against a transaction-level model.
    pend[0] = 0;
    pend[1] = 0;
    for (int t = 0; t < 150; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) pend[r] = 1'b1;
        else if (!pend[r]) continue;
        else continue;
        pc[r] = 2'($urandom_range(0, 3));
        pd[r] = (pc[r] == 2'b11) ? $urandom : (($urandom & 32'hFFFF0000) | $urandom_range(0, 8));
        pr[r] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
        drive(r, 1'b1, pc[r], pd[r]);
      end
      if (!pend[0] && !pend[1]) begin
        win      = $urandom_range(0, 1);
        pend[win] = 1'b1;
        pc[win]  = 2'($urandom_range(0, 3));
        pd[win]  = $urandom_range(0, 8);
        pr[win]  = 0;
        drive(win, 1'b1, pc[win], pd[win]);
      end
      win = (pend[0] && pend[1]) ? (1 - last_who) : (pend[0] ? 0 : 1);
      n   = int'(pd[win][CNT_W-1:0]);
      if (pc[win] == 2'b11) begin
        ee = 1; er = 1'b0;
      end else if (n == 0) begin
        ee = 0; er = 1'b0;
      end else if (pr[win] != 0 && pr[win] <= n) begin
        ee = pr[win]; er = 1'b1;
      end else begin
        ee = n; er = 1'b0;
      end
      serve_one(win, pc[win], pd[win], pr[win], ee, er, 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", t));
      pend[win] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Two-requester command sequencer and arbiter in front of the 32-bit 4-mode counter.
- Each requester submits a command: a load (CHARGE), or a count run of N enabled cycles in mode up, down or down-by-3.
- The block arbitrates round-robin and drives the counter's ENABLE/MODO/D for the exact number of cycles.
- It reports completion per requester and flags early termination on counter ripple-carry.

Parameters:
- WIDTH, 32, counter data width (D/Q).
- CNT_W, 16, width of the run-length field; run length = DATA[CNT_W-1:0].
- STOP_ON_RCO, 1, when 1 a count run ends early on CNT_RCO=1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_A  in  1  requester A command request; held high until DONE_A.
- CMD_A  in  2  A mode: 00 up, 01 down, 10 down-by-3, 11 CHARGE.
- DATA_A  in  WIDTH  A load value (CHARGE) or run length (low CNT_W bits).
- REQ_B, CMD_B, DATA_B  in  1/2/WIDTH  same for requester B.
- GNT_A, GNT_B  out  1  owner indication, high from grant through DONE cycle.
- DONE_A, DONE_B  out  1  one-cycle completion pulse.
- RCO_HIT  out  1  valid with DONE pulse: run ended by CNT_RCO.
- BUSY  out  1  high in any state other than IDLE.
- CNT_ENABLE  out  1  to counter ENABLE.
- CNT_MODO  out  2  to counter MODO.
- CNT_D  out  WIDTH  to counter D.
- CNT_RCO  in  1  from counter RCO.

Behaviour:
- All outputs registered. Async reset (RESET=0) values:
  - GNT_*, DONE_*, RCO_HIT, BUSY, CNT_ENABLE = 0; CNT_D = 0; CNT_MODO = 2'b11.
  - State = IDLE; last-served pointer = B, so A has first priority.
- FSM states: IDLE, EXEC, FIN.
- IDLE:
  - If any REQ is high, select the winner: single request wins; if both are high, the requester not served last wins.
  - Latch CMD/DATA into internal regs; set GNT_<w>=1 and BUSY=1.
  - Run-length counter rem = DATA[CNT_W-1:0].
  - CMD=11, or count mode with rem>0: go EXEC. Count mode with rem==0: go FIN directly; CNT_ENABLE never asserted.
- EXEC, CHARGE:
  - Exactly one cycle with CNT_ENABLE=1, CNT_MODO=11, CNT_D=latched DATA; then FIN.
- EXEC, count mode:
  - CNT_ENABLE=1, CNT_MODO=latched CMD, CNT_D=latched DATA for exactly rem cycles.
  - rem decrements each EXEC cycle; leave for FIN after the cycle where rem==1.
- Early stop:
  - If STOP_ON_RCO=1, mode is not CHARGE, and CNT_RCO=1 is sampled in EXEC: go FIN next cycle and set RCO_HIT=1.
  - RCO is sampled registered; one extra enabled cycle after the RCO cycle is permitted (by design).
- FIN:
  - CNT_ENABLE=0, CNT_MODO returns to 11, DONE_<w>=1 for one cycle.
  - GNT_<w> stays high this cycle and clears next. RCO_HIT is valid this cycle only and clears next.
  - Update last-served pointer; return to IDLE.
- Latency:
  - REQ rises in IDLE → GNT at edge+1 → first CNT_ENABLE cycle at edge+1.
  - N-cycle run → DONE at grant+N.
- Back-to-back: a requester still holding REQ in the IDLE cycle after FIN is treated as a new request. Requesters must drop REQ in the cycle DONE is seen.
- Request changes while granted: CMD/DATA changes and REQ drops of the owner are ignored once granted; the command always completes.
- REQ of the non-owner is only evaluated in IDLE.
- Reset mid-run: immediate return to reset values; in-flight command discarded with no DONE.
- rem width: run length is capped at 2^CNT_W - 1; upper DATA bits are ignored in count modes.

Test Plan:
- Reset, then REQ_A, CMD_A=11, DATA_A=32'hDEADBEEF → GNT_A next edge; one cycle CNT_ENABLE=1, CNT_MODO=11, CNT_D=DEADBEEF; DONE_A pulse the following cycle; RCO_HIT=0.
- REQ_A, CMD_A=00, DATA_A=5 → CNT_ENABLE high exactly 5 consecutive cycles with CNT_MODO=00; DONE_A one cycle after the last enable; BUSY low afterwards.
- REQ_A and REQ_B raised together after reset, both CMD=01, DATA=3 → A served first, B second (grant in the IDLE cycle after A's FIN). Repeat with both still requesting → B is served before A on the second round (round-robin).
- REQ_B, CMD_B=10, DATA_B=0 → GNT_B then DONE_B within 2 cycles; CNT_ENABLE never asserted.
- REQ_A, CMD_A=00, DATA_A=100; force CNT_RCO=1 on the 4th enabled cycle (STOP_ON_RCO=1) → at most 5 enabled cycles; DONE_A with RCO_HIT=1.
- Assert RESET=0 asynchronously during the 3rd EXEC cycle of a 10-cycle run → all outputs drop to reset values immediately with no DONE; after release, REQ_B is served normally.
